// File: rtl/ysyx_22050019_dmem_bridge.sv
// Data-memory bridge between the load/store unit and the valid/ready memory bus.
// Latches one LSU request, moves it into the 8-byte lanes, runs one bus
// transaction and stalls the pipeline until the response arrives or the access
// is rejected (misaligned, read+write together) or times out.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an LSU request; latches request fields
// REQ    | mem_req_valid high, fields held until mem_req_ready
// WAIT   | handshake done, waiting for mem_resp_valid or timeout
// DONE   | one-cycle completion: done_o (and err_o if flagged), no stall
module ysyx_22050019_dmem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid_i,
    input  logic              ram_re_i,
    input  logic [63:0]       ram_raddr_i,
    input  logic              ram_we_i,
    input  logic [63:0]       ram_waddr_i,
    input  logic [63:0]       ram_wdata_i,
    input  logic [7:0]        wmask_i,
    output logic [63:0]       ram_rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [63:0]       mem_req_wdata,
    output logic [7:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Down-counter holds remaining WAIT cycles; zero is the last allowed one.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       off_q;

    logic             req_hit;
    logic             illegal;
    logic [63:0]      sel_addr;
    logic [2:0]       sel_off;
    logic [3:0]       mask_pop;
    logic             handshake;
    logic             tmo;
    logic             unused_ok;

    assign req_hit   = lsu_valid_i & (ram_re_i | ram_we_i);
    assign sel_addr  = ram_we_i ? ram_waddr_i : ram_raddr_i;
    assign sel_off   = sel_addr[2:0];
    assign handshake = mem_req_valid & mem_req_ready;
    assign tmo       = (cnt_q == '0);
    assign unused_ok = ^sel_addr;

    // Access width comes from the mask for both reads and writes.
    always_comb begin
        mask_pop = '0;
        for (int i = 0; i < 8; i++) begin
            mask_pop = mask_pop + {3'b000, wmask_i[i]};
        end
    end

    // Reject read+write together and anything spilling past the 8-byte word.
    assign illegal = (ram_re_i & ram_we_i) | (({1'b0, sel_off} + mask_pop) > 4'd8);

    // Stall while a request is being accepted or in flight; never during reset.
    assign stall_o = ~rst & (((state_q == S_IDLE) & req_hit) |
                             (state_q == S_REQ) | (state_q == S_WAIT));

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_hit) begin
                    state_d = illegal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (handshake) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid || tmo) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, request latching, timeout counter and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            off_q         <= '0;
            ram_rdata_o   <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
        end else begin
            state_q <= state_d;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_hit) begin
                        off_q         <= sel_off;
                        mem_req_write <= ram_we_i;
                        mem_req_addr  <= {sel_addr[ADDR_W-1:3], 3'b000};
                        mem_req_wdata <= ram_wdata_i << {sel_off, 3'b000};
                        mem_req_wstrb <= wmask_i << sel_off;
                        if (illegal) begin
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (handshake) begin
                        mem_req_valid <= 1'b0;
                        cnt_q         <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    // A response in the final counted cycle still wins over timeout.
                    if (mem_resp_valid) begin
                        done_o <= 1'b1;
                        if (!mem_req_write) begin
                            ram_rdata_o <= mem_resp_rdata >> {off_q, 3'b000};
                        end
                    end else if (tmo) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_dmem_bridge.sv
// Bench for the data-memory bridge: a small bus responder, a negedge monitor
// that pops expected completions from a scoreboard, and directed accesses.
module tb_ysyx_22050019_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid_i = 1'b0;
    logic        ram_re_i = 1'b0;
    logic [63:0] ram_raddr_i = '0;
    logic        ram_we_i = 1'b0;
    logic [63:0] ram_waddr_i = '0;
    logic [63:0] ram_wdata_i = '0;
    logic [7:0]  wmask_i = '0;
    logic [63:0] ram_rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        err_o;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = '0;

    ysyx_22050019_dmem_bridge #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid_i    (lsu_valid_i),
        .ram_re_i       (ram_re_i),
        .ram_raddr_i    (ram_raddr_i),
        .ram_we_i       (ram_we_i),
        .ram_waddr_i    (ram_waddr_i),
        .ram_wdata_i    (ram_wdata_i),
        .wmask_i        (wmask_i),
        .ram_rdata_o    (ram_rdata_o),
        .stall_o        (stall_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_hs = 0;
    int          n_done = 0;

    // bus responder controls
    int          ready_delay = 0;
    logic        bus_respond = 1'b1;
    logic        stray_resp = 1'b0;
    logic [63:0] bus_word = '0;
    logic        hs_pend = 1'b0;

    // captured at handshake
    logic        hs_write;
    logic [31:0] hs_addr;
    logic [63:0] hs_wdata;
    logic [7:0]  hs_wstrb;

    // previous-cycle request fields for the hold check
    logic        prev_stalled = 1'b0;
    logic        prev_write;
    logic [31:0] prev_addr;
    logic [63:0] prev_wdata;
    logic [7:0]  prev_wstrb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder: ready after ready_delay cycles of valid, response the cycle after handshake.
    initial begin
        int rdy_cnt;
        logic hs;
        rdy_cnt = 0;
        forever begin
            @(posedge clk);
            hs = hs_pend;
            #1;
            mem_resp_valid = (hs && bus_respond && !rst) || stray_resp;
            mem_resp_rdata = bus_word;
            if (mem_req_valid && !rst) begin
                if (rdy_cnt >= ready_delay) begin
                    mem_req_ready = 1'b1;
                end else begin
                    mem_req_ready = 1'b0;
                    rdy_cnt++;
                end
            end else begin
                mem_req_ready = 1'b0;
                rdy_cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pop on completion, handshake capture, request hold check.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("sb_empty_on_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_err", {63'd0, err_o}, {63'd0, e.err});
                    chk("done_rdata", ram_rdata_o, e.rdata);
                end
            end else if (err_o) begin
                chk("err_without_done", {63'd0, err_o}, 64'd0);
            end
            if (prev_stalled) begin
                chk("hold_valid", {63'd0, mem_req_valid}, 64'd1);
                chk("hold_addr", {32'd0, mem_req_addr}, {32'd0, prev_addr});
                chk("hold_wdata", mem_req_wdata, prev_wdata);
                chk("hold_wstrb", {56'd0, mem_req_wstrb}, {56'd0, prev_wstrb});
                chk("hold_write", {63'd0, mem_req_write}, {63'd0, prev_write});
            end
            if (mem_req_valid && mem_req_ready) begin
                n_hs++;
                hs_write = mem_req_write;
                hs_addr  = mem_req_addr;
                hs_wdata = mem_req_wdata;
                hs_wstrb = mem_req_wstrb;
            end
        end
        prev_stalled = !rst && mem_req_valid && !mem_req_ready;
        prev_write   = mem_req_write;
        prev_addr    = mem_req_addr;
        prev_wdata   = mem_req_wdata;
        prev_wstrb   = mem_req_wstrb;
        hs_pend      = !rst && mem_req_valid && mem_req_ready;
    end

    // One LSU access held until done; other inputs scrambled after the first cycle.
    task automatic do_access(input string tag, input logic re, input logic we,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wmask, input logic [63:0] word,
                             input logic exp_err, input logic [63:0] exp_rd,
                             input int exp_stall, input int exp_hs);
        int   stalls;
        int   cyc;
        int   hs0;
        logic done_seen;
        exp_t e;
        @(posedge clk);
        #1;
        bus_word = word;
        e.err = exp_err;
        e.rdata = exp_rd;
        sb.push_back(e);
        hs0 = n_hs;
        lsu_valid_i = 1'b1;
        ram_re_i    = re;
        ram_we_i    = we;
        ram_raddr_i = addr;
        ram_waddr_i = addr;
        ram_wdata_i = wdata;
        wmask_i     = wmask;
        stalls = 0;
        cyc = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
                ram_raddr_i = {$urandom, $urandom};
                ram_waddr_i = {$urandom, $urandom};
                ram_wdata_i = {$urandom, $urandom};
                wmask_i     = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (done_o) begin
                done_seen = 1'b1;
                chk({tag, "_stall_in_done"}, {63'd0, stall_o}, 64'd0);
            end else if (stall_o) begin
                stalls++;
            end
        end
        if (!done_seen) begin
            chk({tag, "_done_bound"}, 64'd0, 64'd1);
            sb.delete();
        end
        chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_stall + 1));
        chk({tag, "_handshakes"}, 64'(n_hs - hs0), 64'(exp_hs));
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b0;
        ram_re_i    = 1'b0;
        ram_we_i    = 1'b0;
    endtask

    initial begin
        int d0;
        // reset with a request pending: no stall, all outputs cleared
        lsu_valid_i = 1'b1;
        ram_re_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_done_err", {62'd0, done_o, err_o}, 64'd0);
        chk("rst_rdata", ram_rdata_o, 64'd0);
        chk("rst_req_fields", {mem_req_addr, 23'd0, mem_req_write, mem_req_wstrb}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lsu_valid_i = 1'b0;

        // no request without lsu_valid, or with lsu_valid but no re/we
        d0 = n_done;
        @(negedge clk);
        chk("novalid_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b1;
        ram_re_i = 1'b0;
        @(negedge clk);
        chk("noop_stall", {63'd0, stall_o}, 64'd0);
        repeat (2) @(negedge clk);
        chk("noop_no_done", 64'(n_done - d0), 64'd0);
        chk("noop_no_valid", {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b0;

        // minimum-latency read
        do_access("rd_half", 1'b1, 1'b0, 64'h8000_0006, 64'h0, 8'h03,
                  64'h1122_3344_5566_7788, 1'b0, 64'h1122, 3, 1);
        chk("rd_half_addr", {32'd0, hs_addr}, 64'h8000_0000);
        chk("rd_half_write", {63'd0, hs_write}, 64'd0);

        // byte write with ready held low for 5 cycles
        ready_delay = 5;
        do_access("wr_byte", 1'b0, 1'b1, 64'h8000_0003, 64'hAB, 8'h01,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1122, 8, 1);
        ready_delay = 0;
        chk("wr_byte_addr", {32'd0, hs_addr}, 64'h8000_0000);
        chk("wr_byte_write", {63'd0, hs_write}, 64'd1);
        chk("wr_byte_wdata", hs_wdata, 64'h0000_0000_AB00_0000);
        chk("wr_byte_wstrb", {56'd0, hs_wstrb}, 64'h08);

        // word write crossing the 8-byte boundary
        do_access("misalign", 1'b0, 1'b1, 64'h8000_0006, 64'h1234_5678, 8'h0F,
                  64'h0, 1'b1, 64'h1122, 1, 0);

        // upper-word read
        do_access("rd_word", 1'b1, 1'b0, 64'h8000_0004, 64'h0, 8'h0F,
                  64'hDEAD_BEEF_0123_4567, 1'b0, 64'hDEAD_BEEF, 3, 1);
        chk("rd_word_addr", {32'd0, hs_addr}, 64'h8000_0000);

        // timeout: four WAIT cycles, read data untouched
        bus_respond = 1'b0;
        do_access("timeout", 1'b1, 1'b0, 64'h8000_0010, 64'h0, 8'hFF,
                  64'h5555_5555_5555_5555, 1'b1, 64'hDEAD_BEEF, 6, 1);
        bus_respond = 1'b1;

        // read and write together
        do_access("re_we", 1'b1, 1'b1, 64'h8000_0000, 64'h0, 8'h01,
                  64'h0, 1'b1, 64'hDEAD_BEEF, 1, 0);

        // boundary: offset 7 byte is legal, offset 7 half is not
        do_access("rd_off7_b", 1'b1, 1'b0, 64'h8000_0007, 64'h0, 8'h01,
                  64'h5A00_0000_0000_0000, 1'b0, 64'h5A, 3, 1);
        do_access("rd_off7_h", 1'b1, 1'b0, 64'h8000_0007, 64'h0, 8'h03,
                  64'h0, 1'b1, 64'h5A, 1, 0);

        // doubleword write at offset 0
        do_access("wr_dword", 1'b0, 1'b1, 64'h8000_0018, 64'h0102_0304_0506_0708, 8'hFF,
                  64'h0, 1'b0, 64'h5A, 3, 1);
        chk("wr_dword_addr", {32'd0, hs_addr}, 64'h8000_0018);
        chk("wr_dword_wdata", hs_wdata, 64'h0102_0304_0506_0708);
        chk("wr_dword_wstrb", {56'd0, hs_wstrb}, 64'hFF);

        // reset during WAIT: abort, stray response ignored, no completion
        bus_respond = 1'b0;
        d0 = n_done;
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b1;
        ram_re_i = 1'b1;
        ram_raddr_i = 64'h8000_0020;
        wmask_i = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstw_in_wait_stall", {63'd0, stall_o}, 64'd1);
        rst = 1'b1;
        lsu_valid_i = 1'b0;
        ram_re_i = 1'b0;
        @(negedge clk);
        chk("rstw_stall_forced", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray_resp = 1'b1;
        bus_word = 64'hCAFE_CAFE_CAFE_CAFE;
        @(negedge clk);
        chk("rstw_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rstw_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        stray_resp = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstw_no_done", 64'(n_done - d0), 64'd0);
        chk("rstw_rdata", ram_rdata_o, 64'd0);
        bus_respond = 1'b1;

        // recovery read after the abort
        do_access("rd_after_rst", 1'b1, 1'b0, 64'h8000_0001, 64'h0, 8'h01,
                  64'h0000_0000_0000_BB00, 1'b0, 64'hBB, 3, 1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "bench time limit");
    end

endmodule
